// File: rtl/text_writer.sv
// Terminal text writer: turns char/attr words and terminal commands into SDRAM
// text-page writes and keeps the video controller's scroll/cursor registers current.
module text_writer #(
    parameter int          COLUMNS       = 80,
    parameter int          ROWS          = 51,
    parameter int          ROW_SIZE      = 80,
    parameter int          BASE_ADDRESS  = 0,
    parameter logic [31:0] BLANK         = 32'h0700_0020,
    parameter logic [3:0]  IDX_NOP       = 4'd0,
    parameter logic [3:0]  IDX_BASE      = 4'd1,
    parameter logic [3:0]  IDX_FIRST_ROW = 4'd2,
    parameter logic [3:0]  IDX_CURSOR    = 4'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_ctrl,
    input  logic [31:0] in_data,
    output logic        wr_request,
    output logic [22:0] wr_address,
    output logic [8:0]  wr_burst_length,
    output logic [31:0] wr_data,
    input  logic        wr_next,
    input  logic        wr_done,
    output logic [3:0]  register_index,
    output logic [22:0] register_value
);
    localparam int          PAGE_END = BASE_ADDRESS + ROWS * ROW_SIZE;
    localparam logic [22:0] BASE_A   = 23'(BASE_ADDRESS);
    localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
    localparam logic [6:0]  LAST_COL = 7'(COLUMNS - 1);

    localparam logic [1:0] C_PUT = 2'b00, C_NL = 2'b01, C_SET = 2'b10, C_CLR = 2'b11;

    typedef enum logic [2:0] {
        ST_CLEAR, ST_REGS, ST_IDLE, ST_PUT, ST_SCROLL, ST_SEEK
    } state_t;

    state_t      state, state_nx;
    logic [22:0] top_addr, row_addr, clr_addr;
    logic [5:0]  cur_row, clr_cnt, seek_cnt;
    logic [6:0]  cur_col;
    logic [8:0]  word_cnt;
    logic        q_base, q_first, q_cursor;

    logic        accept, done, launch, last_pulse;
    logic [22:0] l_addr;
    logic [8:0]  l_len;
    logic [31:0] l_data;
    logic [7:0]  col_inc;
    logic [5:0]  set_row;
    logic [6:0]  set_col;

    // Advance by one row, wrapping at the end of the page exactly as the video controller does.
    function automatic logic [22:0] row_step(input logic [22:0] a);
        logic [23:0] s;
        s = {1'b0, a} + 24'(ROW_SIZE);
        if (s >= 24'(PAGE_END)) return BASE_A;
        return s[22:0];
    endfunction

    assign in_ready   = (state == ST_IDLE);
    assign accept     = in_valid && in_ready;
    assign done       = wr_request && wr_done;
    assign col_inc    = {1'b0, cur_col} + 8'd1;
    assign set_row    = (in_data[12:7] > LAST_ROW) ? LAST_ROW : in_data[12:7];
    assign set_col    = (in_data[6:0]  > LAST_COL) ? LAST_COL : in_data[6:0];
    assign last_pulse = (2'(q_base) + 2'(q_first) + 2'(q_cursor)) <= 2'd1;

    always_comb begin
        state_nx       = state;
        launch         = 1'b0;
        l_addr         = clr_addr;
        l_len          = 9'(ROW_SIZE);
        l_data         = BLANK;
        register_index = IDX_NOP;
        register_value = '0;
        case (state)
            ST_CLEAR: begin
                if (!wr_request) launch = 1'b1;
                else if (wr_done && clr_cnt == LAST_ROW) state_nx = ST_REGS;
            end
            ST_SCROLL: begin
                l_addr = top_addr;
                if (!wr_request) launch = 1'b1;
                else if (wr_done) state_nx = ST_REGS;
            end
            ST_PUT: begin
                // A wrap on the bottom row has to blank a row before reporting the cursor.
                if (done)
                    state_nx = (col_inc == 8'(COLUMNS) && cur_row == LAST_ROW) ? ST_SCROLL : ST_REGS;
            end
            ST_SEEK: begin
                if (seek_cnt == '0) state_nx = ST_REGS;
            end
            ST_REGS: begin
                if (q_base) begin
                    register_index = IDX_BASE;
                    register_value = BASE_A;
                end else if (q_first) begin
                    register_index = IDX_FIRST_ROW;
                    register_value = top_addr;
                end else if (q_cursor) begin
                    register_index = IDX_CURSOR;
                    register_value = {10'd0, cur_row, cur_col};
                end
                if (last_pulse) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (in_valid) begin
                    case (in_ctrl)
                        C_PUT: begin
                            launch   = 1'b1;
                            l_addr   = 23'(row_addr + {16'd0, cur_col});
                            l_len    = 9'd1;
                            l_data   = in_data;
                            state_nx = ST_PUT;
                        end
                        C_NL: begin
                            if (cur_row == LAST_ROW) begin
                                launch   = 1'b1;
                                l_addr   = top_addr;
                                state_nx = ST_SCROLL;
                            end else begin
                                state_nx = ST_REGS;
                            end
                        end
                        C_SET: state_nx = ST_SEEK;
                        default: begin
                            launch   = 1'b1;
                            l_addr   = BASE_A;
                            state_nx = ST_CLEAR;
                        end
                    endcase
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_CLEAR;
            wr_request      <= 1'b0;
            wr_address      <= '0;
            wr_burst_length <= '0;
            wr_data         <= '0;
            word_cnt        <= '0;
            top_addr        <= BASE_A;
            row_addr        <= BASE_A;
            clr_addr        <= BASE_A;
            clr_cnt         <= '0;
            seek_cnt        <= '0;
            cur_row         <= '0;
            cur_col         <= '0;
            q_base          <= 1'b1;
            q_first         <= 1'b1;
            q_cursor        <= 1'b1;
        end else begin
            state <= state_nx;

            if (launch) begin
                wr_request      <= 1'b1;
                wr_address      <= l_addr;
                wr_burst_length <= l_len;
                wr_data         <= l_data;
                word_cnt        <= '0;
            end else if (wr_request) begin
                if (wr_done) wr_request <= 1'b0;
                else if (wr_next) word_cnt <= word_cnt + 9'd1;
            end

            case (state)
                ST_CLEAR: begin
                    if (done) begin
                        if (clr_cnt == LAST_ROW) begin
                            top_addr <= BASE_A;
                            row_addr <= BASE_A;
                            cur_row  <= '0;
                            cur_col  <= '0;
                        end else begin
                            clr_cnt  <= clr_cnt + 6'd1;
                            clr_addr <= row_step(clr_addr);
                        end
                    end
                end
                ST_SCROLL: begin
                    // The old top row, now blank, becomes the bottom (cursor) row.
                    if (done) begin
                        top_addr <= row_step(top_addr);
                        row_addr <= top_addr;
                        q_first  <= 1'b1;
                        q_cursor <= 1'b1;
                    end
                end
                ST_PUT: begin
                    if (done) begin
                        q_cursor <= 1'b1;
                        if (col_inc == 8'(COLUMNS)) begin
                            cur_col <= '0;
                            if (cur_row != LAST_ROW) begin
                                cur_row  <= cur_row + 6'd1;
                                row_addr <= row_step(row_addr);
                            end
                        end else begin
                            cur_col <= col_inc[6:0];
                        end
                    end
                end
                ST_SEEK: begin
                    if (seek_cnt != '0) begin
                        seek_cnt <= seek_cnt - 6'd1;
                        row_addr <= row_step(row_addr);
                    end else begin
                        q_cursor <= 1'b1;
                    end
                end
                ST_REGS: begin
                    if (q_base)        q_base   <= 1'b0;
                    else if (q_first)  q_first  <= 1'b0;
                    else               q_cursor <= 1'b0;
                end
                ST_IDLE: begin
                    if (accept) begin
                        case (in_ctrl)
                            C_NL: begin
                                cur_col <= '0;
                                if (cur_row != LAST_ROW) begin
                                    cur_row  <= cur_row + 6'd1;
                                    row_addr <= row_step(row_addr);
                                    q_cursor <= 1'b1;
                                end
                            end
                            C_SET: begin
                                cur_row  <= set_row;
                                cur_col  <= set_col;
                                row_addr <= top_addr;
                                seek_cnt <= set_row;
                            end
                            C_CLR: begin
                                clr_cnt  <= '0;
                                clr_addr <= BASE_A;
                                q_first  <= 1'b1;
                                q_cursor <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: an SDRAM write responder and a register-bus
// monitor log traffic; checks compare the logs against hand-derived values.
module tb_text_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [31:0] in_data;
    logic        wr_request;
    logic [22:0] wr_address;
    logic [8:0]  wr_burst_length;
    logic [31:0] wr_data;
    logic        wr_next;
    logic        wr_done;
    logic [3:0]  register_index;
    logic [22:0] register_value;

    text_writer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .wr_request(wr_request), .wr_address(wr_address), .wr_burst_length(wr_burst_length),
        .wr_data(wr_data), .wr_next(wr_next), .wr_done(wr_done),
        .register_index(register_index), .register_value(register_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    int b_addr[$], b_len[$], b_cyc[$], d_cyc[$];
    logic [31:0] b_data[$];
    int r_idx[$], r_val[$], r_cyc[$];
    int bad_addr = 0;
    int ready_cyc;
    bit short_ack = 0, ack_hold = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // SDRAM write port: log each burst, then stream wr_next and a closing wr_done.
    initial begin
        bit active = 0;
        int cnt = 0;
        wr_next = 0;
        wr_done = 0;
        forever begin
            @(negedge clk);
            wr_next = 0;
            wr_done = 0;
            if (!wr_request) active = 0;
            else if (!active) begin
                active = 1;
                cnt = 0;
                b_addr.push_back(int'(wr_address));
                b_len.push_back(int'(wr_burst_length));
                b_data.push_back(wr_data);
                b_cyc.push_back(cyc);
            end else if (!ack_hold) begin
                if (cnt < (short_ack ? 2 : int'(wr_burst_length))) begin
                    wr_next = 1;
                    cnt++;
                end else begin
                    wr_done = 1;
                    d_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (register_index != 4'd0) begin
                r_idx.push_back(int'(register_index));
                r_val.push_back(int'(register_value));
                r_cyc.push_back(cyc);
            end
            if (wr_request && wr_address >= 23'd4080) bad_addr++;
        end
    end

    task automatic clr_logs();
        b_addr.delete(); b_len.delete(); b_data.delete(); b_cyc.delete(); d_cyc.delete();
        r_idx.delete(); r_val.delete(); r_cyc.delete();
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        ready_cyc = cyc;
        chk(tag, in_ready, 1'b1);
    endtask

    // Present one command in a ready cycle and check the accept-cycle handshake.
    task automatic send(input string tag, input logic [1:0] ctrl, input logic [31:0] data,
                        input bit exp_wr);
        clr_logs();
        in_valid = 1;
        in_ctrl  = ctrl;
        in_data  = data;
        @(negedge clk);
        in_valid = 0;
        chk({tag, "_rdy_drop"}, in_ready, 1'b0);
        chk({tag, "_wr_req"}, wr_request, exp_wr);
    endtask

    task automatic chk_cursor_only(input string tag, input int val);
        chk({tag, "_npulse"}, r_idx.size(), 1);
        if (r_idx.size() >= 1) begin
            chk({tag, "_idx"}, r_idx[0], 3);
            chk({tag, "_val"}, r_val[0], val);
        end
    endtask

    initial begin
        reset = 1; in_valid = 0; in_ctrl = 0; in_data = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_wrreq", wr_request, 1'b0);
        chk("rst_addr", wr_address, 0);
        chk("rst_len", wr_burst_length, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_ridx", register_index, 0);
        chk("rst_rval", register_value, 0);

        // Power-up clear with full-length acks.
        clr_logs();
        reset = 0;
        wait_ready("init_ready", 8000);
        chk("init_nburst", b_addr.size(), 51);
        for (int i = 0; i < 51 && i < b_addr.size(); i++) begin
            chk($sformatf("init_addr%0d", i), b_addr[i], i * 80);
            chk($sformatf("init_len%0d", i), b_len[i], 80);
            chk($sformatf("init_data%0d", i), b_data[i], 32'h0700_0020);
        end
        chk("init_gap", b_cyc[1] - d_cyc[0], 2);
        chk("init_npulse", r_idx.size(), 3);
        if (r_idx.size() == 3 && d_cyc.size() > 0) begin
            chk("init_idx0", r_idx[0], 1); chk("init_val0", r_val[0], 0);
            chk("init_idx1", r_idx[1], 2); chk("init_val1", r_val[1], 0);
            chk("init_idx2", r_idx[2], 3); chk("init_val2", r_val[2], 0);
            chk("init_pcyc0", r_cyc[0], d_cyc[$] + 1);
            chk("init_pcyc2", r_cyc[2], d_cyc[$] + 3);
            chk("init_rdycyc", ready_cyc, d_cyc[$] + 4);
        end

        // Put at 0,0.
        send("put0", 2'b00, 32'h1234_0041, 1'b1);
        wait_ready("put0_ready", 100);
        chk("put0_nburst", b_addr.size(), 1);
        if (b_addr.size() == 1) begin
            chk("put0_addr", b_addr[0], 0);
            chk("put0_len", b_len[0], 1);
            chk("put0_data", b_data[0], 32'h1234_0041);
        end
        chk_cursor_only("put0_cur", 1);
        if (r_cyc.size() == 1 && d_cyc.size() == 1) begin
            chk("put0_pcyc", r_cyc[0], d_cyc[0] + 1);
            chk("put0_rdycyc", ready_cyc, d_cyc[0] + 2);
        end

        // Cursor to 2,79 then put: wraps to row 3.
        send("set279", 2'b10, (2 << 7) | 79, 1'b0);
        wait_ready("set279_ready", 100);
        chk("set279_nburst", b_addr.size(), 0);
        chk_cursor_only("set279_cur", 335);
        send("putwrap", 2'b00, 32'hABCD_0042, 1'b1);
        wait_ready("putwrap_ready", 100);
        if (b_addr.size() == 1) chk("putwrap_addr", b_addr[0], 239);
        else chk("putwrap_nburst", b_addr.size(), 1);
        chk_cursor_only("putwrap_cur", 384);

        // Bottom row newline scrolls.
        send("set50", 2'b10, 50 << 7, 1'b0);
        wait_ready("set50_ready", 200);
        chk_cursor_only("set50_cur", 6400);
        send("nl50", 2'b01, 0, 1'b1);
        wait_ready("nl50_ready", 200);
        chk("nl50_nburst", b_addr.size(), 1);
        if (b_addr.size() == 1) begin
            chk("nl50_addr", b_addr[0], 0);
            chk("nl50_len", b_len[0], 80);
            chk("nl50_data", b_data[0], 32'h0700_0020);
        end
        chk("nl50_npulse", r_idx.size(), 2);
        if (r_idx.size() == 2) begin
            chk("nl50_idx0", r_idx[0], 2); chk("nl50_val0", r_val[0], 80);
            chk("nl50_idx1", r_idx[1], 3); chk("nl50_val1", r_val[1], 6400);
        end
        send("put50", 2'b00, 32'h0700_0043, 1'b1);
        wait_ready("put50_ready", 100);
        if (b_addr.size() == 1) chk("put50_addr", b_addr[0], 0);
        else chk("put50_nburst", b_addr.size(), 1);
        chk_cursor_only("put50_cur", 6401);

        // 50 more scrolls (early wr_done acks) bring the top back to 0.
        short_ack = 1;
        for (int k = 1; k <= 50; k++) begin
            send($sformatf("scr%0d", k), 2'b01, 0, 1'b1);
            wait_ready($sformatf("scr%0d_ready", k), 100);
            if (b_addr.size() == 1) chk($sformatf("scr%0d_addr", k), b_addr[0], k * 80);
            else chk($sformatf("scr%0d_nburst", k), b_addr.size(), 1);
            if (r_idx.size() == 2)
                chk($sformatf("scr%0d_first", k), r_val[0], ((k + 1) % 51) * 80);
            else chk($sformatf("scr%0d_npulse", k), r_idx.size(), 2);
        end
        chk("scr_bad_addr", bad_addr, 0);

        // Out-of-range cursor clamps, no SDRAM traffic.
        send("clamp", 2'b10, (63 << 7) | 127, 1'b0);
        wait_ready("clamp_ready", 200);
        chk("clamp_nburst", b_addr.size(), 0);
        chk_cursor_only("clamp_cur", 6479);

        // Clear-screen command.
        send("cls", 2'b11, 0, 1'b1);
        wait_ready("cls_ready", 2000);
        chk("cls_nburst", b_addr.size(), 51);
        if (b_addr.size() == 51) begin
            chk("cls_addr0", b_addr[0], 0);
            chk("cls_addr50", b_addr[50], 4000);
        end
        chk("cls_npulse", r_idx.size(), 2);
        if (r_idx.size() == 2) begin
            chk("cls_idx0", r_idx[0], 2); chk("cls_val0", r_val[0], 0);
            chk("cls_idx1", r_idx[1], 3); chk("cls_val1", r_val[1], 0);
        end
        send("putcls", 2'b00, 32'h0700_0044, 1'b1);
        wait_ready("putcls_ready", 100);
        if (b_addr.size() == 1) chk("putcls_addr", b_addr[0], 0);
        else chk("putcls_nburst", b_addr.size(), 1);

        // Reset in the middle of a held burst.
        ack_hold = 1;
        send("rstmid", 2'b00, 32'h0700_0045, 1'b1);
        repeat (3) @(negedge clk);
        chk("rstmid_held", wr_request, 1'b1);
        reset = 1;
        @(negedge clk);
        chk("rstmid_drop", wr_request, 1'b0);
        chk("rstmid_rdy", in_ready, 1'b0);
        @(negedge clk);
        clr_logs();
        ack_hold = 0;
        reset = 0;
        wait_ready("rstmid_ready", 2000);
        chk("rstmid_nburst", b_addr.size(), 51);
        if (b_addr.size() > 0) chk("rstmid_addr0", b_addr[0], 0);
        chk("rstmid_npulse", r_idx.size(), 3);
        if (r_idx.size() > 0) chk("rstmid_idx0", r_idx[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
